uart_cmd_ctrl: RTL and testbench

//  Frame parser/sequencer sitting between the UART receiver byte stream and the system bus.

---
 rtl/uart_cmd_pkg.sv | 23 ++
 rtl/uart_cmd_ctrl.sv | 175 +++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants and state encoding for the UART command frame parser.
// Frame layout: SYNC, OP, ADDR[4], DATA[4], CSUM (little-endian fields).
package uart_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] OP_READ   = 8'h00;
    localparam logic [7:0] OP_WRITE  = 8'h01;
    localparam int         FRAME_LEN = 11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OP,
        S_ADDR,
        S_DATA,
        S_CSUM,
        S_ISSUE
    } state_t;

    function automatic logic is_legal_op(input logic [7:0] op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction

endpackage

// File: rtl/uart_cmd_ctrl.sv
// Frame parser/sequencer between the UART RX byte stream and the system bus.
// Optional inter-byte timeout is built when UART_CMD_TIMEOUT_EN is defined.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_we,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [DATA_W-1:0] cmd_wdata,
    output logic              err_checksum,
    output logic              err_opcode,
    output logic              err_timeout,
    output logic              busy
);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  xor_q, xor_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        err_checksum_q, err_checksum_d;
    logic        err_opcode_q, err_opcode_d;
    logic        err_timeout_q, err_timeout_d;
    logic        byte_acc;
    logic        timeout_hit;

    assign rx_ready  = (state_q != S_ISSUE);
    assign byte_acc  = rx_valid && rx_ready;
    assign cmd_valid = (state_q == S_ISSUE);
    assign busy      = (state_q != S_IDLE);
    assign cmd_we    = we_q;
    assign cmd_addr  = addr_q[ADDR_W-1:0];
    assign cmd_wdata = wdata_q[DATA_W-1:0];
    assign err_checksum = err_checksum_q;
    assign err_opcode   = err_opcode_q;
    assign err_timeout  = err_timeout_q;

`ifdef UART_CMD_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             counting;

    // Counter only runs while a partial frame is outstanding; any accepted byte restarts it.
    always_comb begin
        counting    = (state_q == S_OP) || (state_q == S_ADDR) ||
                      (state_q == S_DATA) || (state_q == S_CSUM);
        tmo_d       = tmo_q + 1'b1;
        if (!counting || byte_acc) begin
            tmo_d = '0;
        end
        timeout_hit = counting && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // A timeout wins over a byte arriving in the same cycle, which is then dropped.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        xor_d          = xor_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        we_d           = we_q;
        err_checksum_d = 1'b0;
        err_opcode_d   = 1'b0;
        err_timeout_d  = 1'b0;
        if (timeout_hit) begin
            state_d       = S_IDLE;
            err_timeout_d = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (byte_acc && (rx_data == SYNC_BYTE)) begin
                        state_d = S_OP;
                    end
                end
                S_OP: begin
                    if (byte_acc) begin
                        if (is_legal_op(rx_data)) begin
                            we_d    = rx_data[0];
                            xor_d   = rx_data;
                            idx_d   = 2'd0;
                            state_d = S_ADDR;
                        end else begin
                            err_opcode_d = 1'b1;
                            state_d      = S_IDLE;
                        end
                    end
                end
                S_ADDR: begin
                    if (byte_acc) begin
                        addr_d[{idx_q, 3'b000} +: 8] = rx_data;
                        xor_d = xor_q ^ rx_data;
                        idx_d = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_d = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (byte_acc) begin
                        wdata_d[{idx_q, 3'b000} +: 8] = rx_data;
                        xor_d = xor_q ^ rx_data;
                        idx_d = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_d = S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (byte_acc) begin
                        if (rx_data == xor_q) begin
                            state_d = S_ISSUE;
                        end else begin
                            err_checksum_d = 1'b1;
                            state_d        = S_IDLE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (cmd_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            idx_q          <= 2'd0;
            xor_q          <= 8'h00;
            addr_q         <= 32'h0;
            wdata_q        <= 32'h0;
            we_q           <= 1'b0;
            err_checksum_q <= 1'b0;
            err_opcode_q   <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            xor_q          <= xor_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            we_q           <= we_d;
            err_checksum_q <= err_checksum_d;
            err_opcode_q   <= err_opcode_d;
            err_timeout_q  <= err_timeout_d;
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed frames plus randomized frame mix
// compared against a frame-level expectation model kept in the bench.
module tb_uart_cmd_ctrl;
    import uart_cmd_pkg::*;

    localparam int TMO = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        cmd_valid;
    logic        cmd_ready = 1'b1;
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        err_checksum;
    logic        err_opcode;
    logic        err_timeout;
    logic        busy;

    always #5 clk = ~clk;

    uart_cmd_ctrl #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we(cmd_we),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .err_checksum(err_checksum),
        .err_opcode(err_opcode),
        .err_timeout(err_timeout),
        .busy(busy)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    int   checks = 0;
    int   errors = 0;
    cmd_t gotCmds[$];
    int   validCycles = 0;
    int   csumErrs = 0;
    int   opErrs = 0;
    int   tmoErrs = 0;
    int   expCsum = 0;
    int   expOp = 0;
    int   expCmds = 0;

    task automatic checkOutput(input string tag, input logic [64:0] observed, input logic [64:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Monitor samples on the falling edge; inputs only change just after rising edges.
    logic prevCsum = 1'b0, prevOp = 1'b0, prevTmo = 1'b0, prevValid = 1'b0, prevHs = 1'b0;
    cmd_t prevCmd, curCmd;
    always @(negedge clk) begin
        curCmd = {cmd_we, cmd_addr, cmd_wdata};
        if (err_checksum) checkOutput("err_checksum_width", 65'(prevCsum), 65'd0);
        if (err_opcode)   checkOutput("err_opcode_width", 65'(prevOp), 65'd0);
        if (err_timeout)  checkOutput("err_timeout_width", 65'(prevTmo), 65'd0);
        if (err_checksum || err_opcode || err_timeout)
            checkOutput("err_exclusive", 65'($countones({err_checksum, err_opcode, err_timeout})), 65'd1);
        if (cmd_valid && prevValid && !prevHs)
            checkOutput("cmd_stable", 65'(curCmd), 65'(prevCmd));
        csumErrs += int'(err_checksum);
        opErrs   += int'(err_opcode);
        tmoErrs  += int'(err_timeout);
        if (cmd_valid) validCycles++;
        if (cmd_valid && cmd_ready) gotCmds.push_back(curCmd);
        prevCsum  = err_checksum;
        prevOp    = err_opcode;
        prevTmo   = err_timeout;
        prevValid = cmd_valid;
        prevHs    = cmd_valid && cmd_ready;
        prevCmd   = curCmd;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one byte and returns one cycle after it has been accepted.
    task automatic applyStimulus(input logic [7:0] b);
        int n;
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) checkOutput("rx_ready_wait", 65'(rx_ready), 65'd1);
        step();
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) step();
    endtask

    function automatic logic [7:0] frameCsum(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data);
        logic [7:0] c;
        c = op;
        for (int i = 0; i < 4; i++) c ^= addr[8*i +: 8] ^ data[8*i +: 8];
        return c;
    endfunction

    task automatic sendBody(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                            input logic [7:0] flip);
        applyStimulus(op);
        for (int i = 0; i < 4; i++) applyStimulus(addr[8*i +: 8]);
        for (int i = 0; i < 4; i++) applyStimulus(data[8*i +: 8]);
        applyStimulus(frameCsum(op, addr, data) ^ flip);
    endtask

    task automatic sendFrame(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                             input logic [7:0] flip);
        applyStimulus(SYNC_BYTE);
        sendBody(op, addr, data, flip);
    endtask

    // Releases the bus after an optional hold and waits for the command to drain.
    task automatic finishFrame(input int hold);
        int n;
        rx_valid = 1'b0;
        repeat (hold) step();
        cmd_ready = 1'b1;
        n = 0;
        while (cmd_valid && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) checkOutput("cmd_drain", 65'(cmd_valid), 65'd0);
        step();
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_rx_ready"}, 65'(rx_ready), 65'd1);
        checkOutput({tag, "_cmd_valid"}, 65'(cmd_valid), 65'd0);
        checkOutput({tag, "_cmd_we"}, 65'(cmd_we), 65'd0);
        checkOutput({tag, "_cmd_addr"}, 65'(cmd_addr), 65'd0);
        checkOutput({tag, "_cmd_wdata"}, 65'(cmd_wdata), 65'd0);
        checkOutput({tag, "_errs"}, 65'({err_checksum, err_opcode, err_timeout}), 65'd0);
        checkOutput({tag, "_busy"}, 65'(busy), 65'd0);
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, "_cmds"}, 65'(gotCmds.size()), 65'(expCmds));
        checkOutput({tag, "_csum_errs"}, 65'(csumErrs), 65'(expCsum));
        checkOutput({tag, "_op_errs"}, 65'(opErrs), 65'(expOp));
    endtask

    initial begin
        int          kind, hold, vc0, nGarbage;
        logic [7:0]  op, g;
        logic [31:0] addr, data;
        cmd_t        expCmd;

        // Reset state
        rst = 1'b1;
        step();
        step();
        checkResetValues("reset");
        rst = 1'b0;
        step();

        // Good write frame, bus always ready
        vc0 = validCycles;
        sendFrame(OP_WRITE, 32'h12345678, 32'hDEADBEEF, 8'h00);
        checkOutput("write_valid_latency", 65'(cmd_valid), 65'd1);
        checkOutput("write_rx_ready_low", 65'(rx_ready), 65'd0);
        finishFrame(0);
        expCmds++;
        checkOutput("write_one_valid_cycle", 65'(validCycles - vc0), 65'd1);
        checkOutput("write_fields", 65'(gotCmds[$]), {1'b1, 32'h12345678, 32'hDEADBEEF});
        checkCounters("write");

        // Checksum error, then a clean frame
        sendFrame(OP_WRITE, 32'h12345678, 32'hDEADBEEF, 8'h01);
        checkOutput("csum_err_pulse", 65'(err_checksum), 65'd1);
        checkOutput("csum_no_cmd", 65'(cmd_valid), 65'd0);
        finishFrame(0);
        expCsum++;
        checkCounters("csum");
        sendFrame(OP_WRITE, 32'hCAFEF00D, 32'h0BADC0DE, 8'h00);
        finishFrame(0);
        expCmds++;
        checkOutput("after_csum_fields", 65'(gotCmds[$]), {1'b1, 32'hCAFEF00D, 32'h0BADC0DE});

        // Garbage ahead of a read frame
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        applyStimulus(8'h5A);
        checkOutput("garbage_not_busy", 65'(busy), 65'd0);
        sendFrame(OP_READ, 32'hA5A5_0010, 32'h0000_00A5, 8'h00);
        finishFrame(0);
        expCmds++;
        checkOutput("read_fields", 65'(gotCmds[$]), {1'b0, 32'hA5A5_0010, 32'h0000_00A5});
        checkCounters("read");

        // Illegal opcode
        applyStimulus(SYNC_BYTE);
        applyStimulus(8'h07);
        checkOutput("opcode_err_pulse", 65'(err_opcode), 65'd1);
        checkOutput("opcode_busy_drop", 65'(busy), 65'd0);
        idle(1);
        expOp++;
        checkCounters("opcode");

        // Bus back-pressure for 20 cycles with a byte waiting upstream
        cmd_ready = 1'b0;
        sendFrame(OP_WRITE, 32'h0000_1234, 32'h5555_AAAA, 8'h00);
        rx_data  = SYNC_BYTE;
        rx_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            checkOutput("hold_rx_ready", 65'(rx_ready), 65'd0);
            checkOutput("hold_cmd", 65'({cmd_valid, cmd_we, cmd_addr, cmd_wdata}) & {1'b1, 64'h0} | 65'({cmd_we, cmd_addr, cmd_wdata}),
                        {1'b1, 32'h0000_1234, 32'h5555_AAAA} | {1'b1, 64'h0});
            step();
        end
        cmd_ready = 1'b1;
        while (cmd_valid) step();
        expCmds++;
        checkOutput("hold_issued", 65'(gotCmds[$]), {1'b1, 32'h0000_1234, 32'h5555_AAAA});
        step();
        checkOutput("held_sync_taken", 65'(busy), 65'd1);
        sendBody(OP_READ, 32'h0000_0BEE, 32'h0, 8'h00);
        finishFrame(0);
        expCmds++;
        checkOutput("held_sync_frame", 65'(gotCmds[$]), {1'b0, 32'h0000_0BEE, 32'h0});

        // Reset mid-DATA and during S_ISSUE
        applyStimulus(SYNC_BYTE);
        applyStimulus(OP_WRITE);
        for (int i = 0; i < 6; i++) applyStimulus(8'h11 * (i + 1));
        rst = 1'b1;
        step();
        checkResetValues("rst_data");
        rst = 1'b0;
        rx_valid = 1'b0;
        step();
        cmd_ready = 1'b0;
        sendFrame(OP_WRITE, 32'hFFFF_0000, 32'h1234_5678, 8'h00);
        rx_valid = 1'b0;
        step();
        checkOutput("pre_rst_issue", 65'(cmd_valid), 65'd1);
        rst = 1'b1;
        step();
        checkResetValues("rst_issue");
        rst = 1'b0;
        cmd_ready = 1'b1;
        step();
        checkCounters("after_rst");
        sendFrame(OP_READ, 32'h0000_4000, 32'h0, 8'h00);
        finishFrame(0);
        expCmds++;
        checkOutput("post_rst_fields", 65'(gotCmds[$]), {1'b0, 32'h0000_4000, 32'h0});

`ifdef UART_CMD_TIMEOUT_EN
        // Timeout after the third address byte, then a 49-cycle gap that must survive
        applyStimulus(SYNC_BYTE);
        applyStimulus(OP_WRITE);
        for (int i = 0; i < 3; i++) applyStimulus(8'h42);
        rx_valid = 1'b0;
        hold = 0;
        for (int i = 1; i <= 60 && hold == 0; i++) begin
            step();
            if (err_timeout) hold = i;
        end
        checkOutput("timeout_cycle", 65'(hold), 65'(TMO));
        checkOutput("timeout_idle", 65'(busy), 65'd0);
        applyStimulus(SYNC_BYTE);
        applyStimulus(OP_WRITE);
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        applyStimulus(8'h03);
        idle(TMO - 2);
        applyStimulus(8'h04);
        for (int i = 0; i < 4; i++) applyStimulus(8'h00);
        applyStimulus(frameCsum(OP_WRITE, 32'h04030201, 32'h0));
        finishFrame(0);
        expCmds++;
        checkOutput("gap_no_timeout", 65'(tmoErrs), 65'd1);
        checkOutput("gap_fields", 65'(gotCmds[$]), {1'b1, 32'h04030201, 32'h0});
`endif

        // Randomized frame mix
        for (int f = 0; f < 40; f++) begin
            kind = int'($urandom_range(0, 4));
            op   = ($urandom_range(0, 1) == 1) ? OP_WRITE : OP_READ;
            addr = $urandom;
            data = $urandom;
            hold = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
            if (kind == 4) begin
                nGarbage = int'($urandom_range(1, 5));
                for (int i = 0; i < nGarbage; i++) begin
                    g = 8'($urandom);
                    if (g == SYNC_BYTE) g = 8'h3C;
                    applyStimulus(g);
                end
            end
            cmd_ready = (hold == 0);
            if (kind == 2) begin
                sendFrame(op, addr, data, 8'($urandom_range(1, 255)));
                finishFrame(0);
                expCsum++;
            end else if (kind == 3) begin
                applyStimulus(SYNC_BYTE);
                applyStimulus(8'($urandom_range(2, 255)));
                finishFrame(0);
                expOp++;
            end else begin
                sendFrame(op, addr, data, 8'h00);
                finishFrame(hold);
                expCmds++;
                expCmd = {op[0], addr, data};
                checkOutput("rand_fields", 65'(gotCmds[$]), 65'(expCmd));
            end
            cmd_ready = 1'b1;
            checkCounters("rand");
        end
        checkOutput("frame_len_bytes", 65'(FRAME_LEN), 65'(1 + 1 + 4 + 4 + 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
